fetch_stage: RTL and testbench

Instruction fetch stage sitting between the program counter and decode. Holds the fetch PC and advances it by 4 per fetched word. Issues one outstanding request at a time to instruction memory and delivers {pc, instr} to decode over a valid/ready handshake. Accepts a one-cycle redirect (branch/jump) that flushes in-flight and buffered work.

---
 rtl/fetch_stage.sv | 107 ++++++++++
 tb/tb_fetch_stage.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: walks the PC, keeps one memory request in flight, and
// hands {pc, instr} to decode over valid/ready. A redirect flushes in-flight and buffered work.
module fetch_stage #(
  parameter int unsigned           ADDR_W   = 32,
  parameter int unsigned           DATA_W   = 32,
  parameter logic [ADDR_W-1:0]     RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_instr,
  input  logic              out_ready
);

  localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  typedef enum logic [1:0] {
    ST_ISSUE = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] req_pc;
  logic              kill;
  logic [DATA_W-1:0] held_instr;
  logic              slot_free;

  // Request goes out whenever we are idle, unless a redirect is about to move the PC.
  assign imem_req  = rst_n && (state == ST_ISSUE) && !redirect_valid;
  assign imem_addr = pc;
  assign slot_free = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      req_pc     <= '0;
      state      <= ST_ISSUE;
      kill       <= 1'b0;
      held_instr <= '0;
      out_valid  <= 1'b0;
      out_pc     <= '0;
      out_instr  <= '0;
    end else if (redirect_valid) begin
      // Redirect wins: drop the presented word and any buffered/arriving data.
      pc        <= redirect_pc & ALIGN_MASK;
      out_valid <= 1'b0;
      case (state)
        ST_WAIT: begin
          if (imem_rvalid) begin
            kill  <= 1'b0;
            state <= ST_ISSUE;
          end else begin
            kill <= 1'b1;
          end
        end
        default: state <= ST_ISSUE;
      endcase
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      case (state)
        ST_ISSUE: begin
          req_pc <= pc;
          pc     <= pc + PC_STEP;
          state  <= ST_WAIT;
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            if (kill) begin
              kill  <= 1'b0;
              state <= ST_ISSUE;
            end else if (slot_free) begin
              out_valid <= 1'b1;
              out_pc    <= req_pc;
              out_instr <= imem_rdata;
              state     <= ST_ISSUE;
            end else begin
              held_instr <= imem_rdata;
              state      <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (slot_free) begin
            out_valid <= 1'b1;
            out_pc    <= req_pc;
            out_instr <= held_instr;
            state     <= ST_ISSUE;
          end
        end
        default: state <= ST_ISSUE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: random memory latency, back-pressure and redirects
// checked against a program-order stream model and a latency-driven memory model.
module tb_fetch_stage;

  localparam int unsigned AW     = 32;
  localparam int unsigned DW     = 32;
  localparam logic [31:0] RST_PC = 32'hFFFF_FFF0;

  logic          clk;
  logic          rst_n;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_rvalid;
  logic [DW-1:0] imem_rdata;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          out_valid;
  logic [AW-1:0] out_pc;
  logic [DW-1:0] out_instr;
  logic          out_ready;

  fetch_stage #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .RESET_PC(RST_PC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_pc        (out_pc),
    .out_instr     (out_instr),
    .out_ready     (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: next expected request/delivery address in program order, one pending response.
  logic [31:0] exp_req_pc;
  logic [31:0] exp_out_pc;
  logic [31:0] paddr;
  bit          pend;
  int unsigned cnt;
  bit          prev_hold;
  bit          prev_redir;
  logic [31:0] prev_pc;
  logic [31:0] prev_instr;
  int          idle;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F ^ {a[15:0], a[31:16]};
  endfunction

  task automatic model_reset();
    exp_req_pc = RST_PC;
    exp_out_pc = RST_PC;
    paddr      = '0;
    pend       = 1'b0;
    cnt        = 0;
    prev_hold  = 1'b0;
    prev_redir = 1'b0;
    prev_pc    = '0;
    prev_instr = '0;
    idle       = 0;
  endtask

  // One call = n cycles; entered and left at a falling edge.
  task automatic run(input int n, input int unsigned lat_lo, input int unsigned lat_hi,
                     input int unsigned ready_pct, input int unsigned redir_pct,
                     input bit ideal, input bit stall, input bit spur);
    logic [31:0] tgt;
    bit          redir;
    for (int c = 0; c < n; c++) begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      if (pend) begin
        if (cnt <= 1) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(paddr);
          pend        = 1'b0;
        end else begin
          cnt--;
        end
      end else if (spur && $urandom_range(0, 7) == 0) begin
        imem_rvalid = 1'b1;
      end
      redir = ($urandom_range(0, 99) < redir_pct);
      case ($urandom_range(0, 2))
        0:       tgt = 32'h0000_0100 + ($urandom & 32'h0000_00FF);
        1:       tgt = 32'hFFFF_FFE0 + ($urandom & 32'h0000_001F);
        default: tgt = $urandom;
      endcase
      redirect_valid = redir;
      redirect_pc    = tgt;
      out_ready      = ($urandom_range(0, 99) < ready_pct);
      #1;
      if (prev_redir) check("flush_after_redirect", 64'(out_valid), 64'(0));
      if (prev_hold) begin
        check("stall_valid", 64'(out_valid), 64'(1));
        check("stall_pc", 64'(out_pc), 64'(prev_pc));
        check("stall_instr", 64'(out_instr), 64'(prev_instr));
      end
      if (ideal) begin
        check("ideal_req", 64'(imem_req), 64'(c % 2 == 0));
        check("ideal_valid", 64'(out_valid), 64'((c >= 2) && (c % 2 == 0)));
      end
      if (stall && c >= 2) check("stall_no_req", 64'(imem_req), 64'(0));
      if (redir) check("req_blocked_by_redirect", 64'(imem_req), 64'(0));
      if (imem_req) begin
        check("single_outstanding", 64'(pend), 64'(0));
        check("req_addr", 64'(imem_addr), 64'(exp_req_pc));
        exp_req_pc = exp_req_pc + 32'd4;
        pend  = 1'b1;
        cnt   = $urandom_range(lat_lo, lat_hi);
        paddr = imem_addr;
      end
      if (out_valid && out_ready) begin
        check("out_pc", 64'(out_pc), 64'(exp_out_pc));
        check("out_instr", 64'(out_instr), 64'(mem_word(exp_out_pc)));
        exp_out_pc = exp_out_pc + 32'd4;
        idle = 0;
      end
      if (redir) begin
        exp_req_pc = tgt & ~32'h3;
        exp_out_pc = tgt & ~32'h3;
        idle = 0;
      end
      prev_redir = redir;
      prev_hold  = out_valid && !out_ready && !redir;
      prev_pc    = out_pc;
      prev_instr = out_instr;
      idle++;
      if (idle > 60) begin
        check("watchdog_idle", 64'(idle), 64'(0));
        idle = 0;
      end
      @(negedge clk);
    end
  endtask

  // Async reset while a 3-cycle response is outstanding; its late data must be ignored.
  task automatic mid_reset();
    for (int i = 0; i < 20 && !pend; i++) run(1, 3, 3, 100, 0, 1'b0, 1'b0, 1'b0);
    check("mid_reset_pending", 64'(pend), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_req", 64'(imem_req), 64'(0));
    check("async_rst_valid", 64'(out_valid), 64'(0));
    check("async_rst_pc", 64'(out_pc), 64'(0));
    check("async_rst_instr", 64'(out_instr), 64'(0));
    check("async_rst_addr", 64'(imem_addr), 64'(RST_PC));
    imem_rvalid    = 1'b1;
    imem_rdata     = 32'hBAD0_BAD0;
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    @(negedge clk);
    check("rst_held_valid", 64'(out_valid), 64'(0));
    rst_n = 1'b1;
    model_reset();
    #1;
    check("post_rst_req", 64'(imem_req), 64'(1));
    check("post_rst_addr", 64'(imem_addr), 64'(RST_PC));
    exp_req_pc = RST_PC + 32'd4;
    pend  = 1'b1;
    cnt   = 1;
    paddr = RST_PC;
    @(negedge clk);
  endtask

  initial begin
    rst_n          = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_req", 64'(imem_req), 64'(0));
    check("rst_addr", 64'(imem_addr), 64'(RST_PC));
    check("rst_valid", 64'(out_valid), 64'(0));
    check("rst_pc", 64'(out_pc), 64'(0));
    check("rst_instr", 64'(out_instr), 64'(0));
    rst_n = 1'b1;

    run(20, 1, 1, 100, 0, 1'b1, 1'b0, 1'b0);   // ideal stream across the address wrap
    run(6, 1, 1, 0, 0, 1'b0, 1'b1, 1'b0);      // decode stalled: HOLD, no further request
    run(12, 1, 1, 100, 0, 1'b0, 1'b0, 1'b0);   // drain buffered words in order
    run(80, 3, 3, 100, 15, 1'b0, 1'b0, 1'b0);  // slow memory with redirects during WAIT
    run(600, 1, 3, 60, 8, 1'b0, 1'b0, 1'b1);   // fully random traffic
    mid_reset();
    run(300, 1, 3, 70, 6, 1'b0, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
